alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_pkg.sv | 41 ++++
 rtl/alu_regfile.sv | 42 ++++
 rtl/alu_sequencer.sv | 121 ++++++++++++
 tb/tb_alu_sequencer.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: op-codes, sequencer states, flag
// bundle and the decode helpers used by both datapath and control.
package alu_pkg;

    localparam int DATA_W = 8;

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;
    localparam logic [4:0] OP_INC = 5'b01000;
    localparam logic [4:0] OP_DEC = 5'b01001;
    localparam logic [4:0] OP_NOT = 5'b00110;
    localparam logic [4:0] OP_CLR = 5'b01110;
    localparam logic [4:0] OP_SET = 5'b01111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } seq_state_t;

    typedef struct packed {
        logic c;
        logic z;
        logic s;
    } flags_t;

    // Anything outside this list retires with err and leaves all state alone.
    function automatic logic op_supported(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_INC, OP_DEC,
            OP_NOT, OP_CLR, OP_SET: return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

    // Only the arithmetic pair takes its carry from the ALU; the rest keep C.
    function automatic logic op_loads_carry(input logic [4:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// Working register array: one synchronous write port and three combinational
// read ports (A operand, B operand, debug).
module alu_regfile
    import alu_pkg::*;
#(
    parameter  int NREGS = 4,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [AW-1:0]     raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    input  logic [AW-1:0]     raddr_d,
    output logic [DATA_W-1:0] rdata_d
);

    logic [DATA_W-1:0] regs [NREGS];

    // NOTE: the array is small and must read as 00 after reset, so it is built
    // from resettable flops rather than a RAM macro.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                // NOTE: sequential state is always assigned with <= so every
                // flop samples pre-edge values regardless of statement order.
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = regs[raddr_a];
    assign rdata_b = regs[raddr_b];
    assign rdata_d = regs[raddr_d];

endmodule

// File: rtl/alu_sequencer.sv
// Three-state command sequencer around an external combinational ALU:
// accept in IDLE, present operands in EXEC, write back result/flags in WB.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter  int NREGS = 4,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [4:0]        cmd_op,
    input  logic [AW-1:0]     cmd_dst,
    input  logic [AW-1:0]     cmd_src,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_c,
    input  logic              alu_z,
    input  logic              alu_s,
    output logic              flag_c,
    output logic              flag_z,
    output logic              flag_s,
    output logic              done,
    output logic              err,
    input  logic [AW-1:0]     rd_sel,
    output logic [DATA_W-1:0] rd_data
);

    seq_state_t        state;
    logic [4:0]        op_q;
    logic [AW-1:0]     dst_q;
    logic [AW-1:0]     src_q;
    logic [DATA_W-1:0] res_q;
    flags_t            alu_flags_q;
    flags_t            flags_q;
    logic [DATA_W-1:0] rf_a;
    logic [DATA_W-1:0] rf_b;
    logic              in_exec;
    logic              in_wb;
    logic              wr_en;

    assign in_exec = (state == EXEC);
    assign in_wb   = (state == WB);
    assign wr_en   = in_wb && op_supported(op_q);

    alu_regfile #(.NREGS(NREGS)) u_regfile (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (wr_en),
        .waddr   (dst_q),
        .wdata   (res_q),
        .raddr_a (dst_q),
        .rdata_a (rf_a),
        .raddr_b (src_q),
        .rdata_b (rf_b),
        .raddr_d (rd_sel),
        .rdata_d (rd_data)
    );

    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latch.
        alu_a  = '0;
        alu_b  = '0;
        alu_op = '0;
        if (in_exec) begin
            alu_a  = rf_a;
            alu_b  = rf_b;
            alu_op = op_q[3:0];
        end
    end

    assign cmd_ready = (state == IDLE);
    assign done      = in_wb;
    assign err       = in_wb && !op_supported(op_q);
    assign flag_c    = flags_q.c;
    assign flag_z    = flags_q.z;
    assign flag_s    = flags_q.s;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            op_q        <= '0;
            dst_q       <= '0;
            src_q       <= '0;
            res_q       <= '0;
            alu_flags_q <= '0;
            flags_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q  <= cmd_op;
                        dst_q <= cmd_dst;
                        src_q <= cmd_src;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    res_q       <= alu_result;
                    alu_flags_q <= '{c: alu_c, z: alu_z, s: alu_s};
                    state       <= WB;
                end
                WB: begin
                    // Register write happens in the regfile on this same edge.
                    if (op_loads_carry(op_q)) begin
                        flags_q <= alu_flags_q;
                    end else if (op_supported(op_q)) begin
                        flags_q.z <= (res_q == '0);
                        flags_q.s <= res_q[DATA_W-1];
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a behavioural reference ALU on the
// ALU-side ports and a register/flag model producing expected results.
module tb_alu_sequencer;

    localparam int NREGS = 4;
    localparam int AW    = $clog2(NREGS);

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [4:0]    cmd_op = '0;
    logic [AW-1:0] cmd_dst = '0;
    logic [AW-1:0] cmd_src = '0;
    logic [7:0]    alu_a, alu_b, alu_result;
    logic [3:0]    alu_op;
    logic          alu_c, alu_z, alu_s;
    logic          flag_c, flag_z, flag_s;
    logic          done, err;
    logic [AW-1:0] rd_sel = '0;
    logic [7:0]    rd_data;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    typedef struct {
        logic [4:0]    op;
        logic [AW-1:0] dst;
        logic [7:0]    a, b, res;
        logic          c, z, s, err;
        int            acc;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] m_r [NREGS];
    logic       m_c, m_z, m_s;

    alu_sequencer #(.NREGS(NREGS)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_dst(cmd_dst), .cmd_src(cmd_src),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_c(alu_c), .alu_z(alu_z), .alu_s(alu_s),
        .flag_c(flag_c), .flag_z(flag_z), .flag_s(flag_s),
        .done(done), .err(err), .rd_sel(rd_sel), .rd_data(rd_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference ALU keyed on the 4-bit op actually driven by the sequencer.
    always_comb begin
        alu_result = 8'h00;
        alu_c      = 1'b0;
        case (alu_op)
            4'b0000: {alu_c, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
            4'b0001: begin alu_result = alu_a - alu_b; alu_c = (alu_a < alu_b); end
            4'b1000: alu_result = alu_a + 8'd1;
            4'b1001: alu_result = alu_a - 8'd1;
            4'b0110: alu_result = ~alu_a;
            4'b1110: alu_result = 8'h00;
            4'b1111: alu_result = 8'hFF;
            default: alu_result = 8'h00;
        endcase
        alu_z = (alu_result == 8'h00);
        alu_s = alu_result[7];
    end

    function automatic exp_t model_apply(input logic [4:0] op, input logic [AW-1:0] dst,
                                         input logic [AW-1:0] src, input int acc);
        exp_t e;
        logic [8:0] w;
        e.op = op; e.dst = dst; e.acc = acc; e.err = 1'b0;
        e.a = m_r[dst]; e.b = m_r[src]; e.res = m_r[dst];
        e.c = m_c; e.z = m_z; e.s = m_s;
        case (op)
            5'b00000: begin w = {1'b0, e.a} + {1'b0, e.b}; e.res = w[7:0]; e.c = w[8]; end
            5'b00001: begin e.res = e.a - e.b; e.c = (e.a < e.b); end
            5'b01000: e.res = e.a + 8'd1;
            5'b01001: e.res = e.a - 8'd1;
            5'b00110: e.res = ~e.a;
            5'b01110: e.res = 8'h00;
            5'b01111: e.res = 8'hFF;
            default:  e.err = 1'b1;
        endcase
        if (!e.err) begin
            e.z = (e.res == 8'h00);
            e.s = e.res[7];
            m_r[dst] = e.res;
            m_c = e.c; m_z = e.z; m_s = e.s;
        end
        return e;
    endfunction

    task automatic run_cmd(input logic [4:0] op, input logic [AW-1:0] dst, input logic [AW-1:0] src);
        exp_t e;
        int guard;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_dst = dst; cmd_src = src;
        guard = 0;
        while (!cmd_ready && guard < 8) begin @(negedge clk); guard++; end
        n_vec++;
        if (!cmd_ready) begin
            $display("FAIL accept_timeout: cmd_ready=%b want 1", cmd_ready);
            n_miss++; cmd_valid = 1'b0; return;
        end
        sb.push_back(model_apply(op, dst, src, cyc));
        @(negedge clk);
        cmd_valid = 1'b0; cmd_op = 5'($urandom); cmd_dst = AW'($urandom); cmd_src = AW'($urandom);
        e = sb[$];
        n_vec++;
        if ({alu_a, alu_b, alu_op} !== {e.a, e.b, op[3:0]}) begin
            $display("FAIL exec_operands: got a=%h b=%h op=%h want a=%h b=%h op=%h",
                     alu_a, alu_b, alu_op, e.a, e.b, op[3:0]);
            n_miss++;
        end
        guard = 0;
        while (!done && guard < 6) begin @(negedge clk); guard++; end
        n_vec++;
        if (!done) begin
            $display("FAIL done_timeout: done=%b want 1", done);
            n_miss++; sb.delete(); return;
        end
        e = sb.pop_front();
        n_vec++;
        if (cyc - e.acc != 2) begin
            $display("FAIL latency: got %0d cycles want 2", cyc - e.acc); n_miss++;
        end
        n_vec++;
        if (err !== e.err) begin
            $display("FAIL err_pulse: got %b want %b (op %b)", err, e.err, e.op); n_miss++;
        end
        n_vec++;
        if ({alu_a, alu_b, alu_op} !== 20'h0) begin
            $display("FAIL wb_alu_idle: got a=%h b=%h op=%h want zeros", alu_a, alu_b, alu_op); n_miss++;
        end
        @(negedge clk);
        rd_sel = e.dst; #1;
        n_vec++;
        if (rd_data !== e.res) begin
            $display("FAIL rd_data R%0d: got %h want %h", e.dst, rd_data, e.res); n_miss++;
        end
        n_vec++;
        if ({flag_c, flag_z, flag_s} !== {e.c, e.z, e.s}) begin
            $display("FAIL flags: got czs=%b%b%b want %b%b%b", flag_c, flag_z, flag_s, e.c, e.z, e.s);
            n_miss++;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        for (int i = 0; i < NREGS; i++) m_r[i] = 8'h00;
        m_c = 1'b0; m_z = 1'b0; m_s = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({done, err, alu_a, alu_b, alu_op, flag_c, flag_z, flag_s} !== 25'h0) begin
            $display("FAIL reset_outputs: done=%b err=%b a=%h b=%h op=%h czs=%b%b%b want all 0",
                     done, err, alu_a, alu_b, alu_op, flag_c, flag_z, flag_s);
            n_miss++;
        end
        reset_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (cmd_ready !== 1'b1) begin
            $display("FAIL reset_ready: got %b want 1", cmd_ready); n_miss++;
        end
        for (int i = 0; i < NREGS; i++) begin
            rd_sel = AW'(i); #1;
            n_vec++;
            if (rd_data !== 8'h00) begin
                $display("FAIL reset_reg R%0d: got %h want 00", i, rd_data); n_miss++;
            end
        end
    endtask

    task automatic test_setup;
        // Build R0=7F by doubling 1 up to 80 then inverting; R1=01.
        run_cmd(5'b01110, 2'd0, 2'd0);
        run_cmd(5'b01000, 2'd0, 2'd0);
        repeat (7) run_cmd(5'b00000, 2'd0, 2'd0);
        run_cmd(5'b00110, 2'd0, 2'd0);
        run_cmd(5'b01110, 2'd1, 2'd1);
        run_cmd(5'b01000, 2'd1, 2'd1);
    endtask

    task automatic test_add;
        run_cmd(5'b00000, 2'd0, 2'd1);
        rd_sel = 2'd0; #1;
        n_vec++;
        if (rd_data !== 8'h80 || {flag_c, flag_z, flag_s} !== 3'b001) begin
            $display("FAIL add_7f_01: got R0=%h czs=%b%b%b want 80 001", rd_data, flag_c, flag_z, flag_s);
            n_miss++;
        end
    endtask

    task automatic test_sub_self;
        run_cmd(5'b01110, 2'd2, 2'd2);
        repeat (5) run_cmd(5'b01000, 2'd2, 2'd0);
        run_cmd(5'b00001, 2'd2, 2'd2);
        rd_sel = 2'd2; #1;
        n_vec++;
        if (rd_data !== 8'h00 || {flag_c, flag_z, flag_s} !== 3'b010) begin
            $display("FAIL sub_self: got R2=%h czs=%b%b%b want 00 010", rd_data, flag_c, flag_z, flag_s);
            n_miss++;
        end
    endtask

    task automatic test_inc_wrap;
        run_cmd(5'b00000, 2'd0, 2'd0);   // 80+80 leaves C=1
        run_cmd(5'b01110, 2'd3, 2'd3);
        run_cmd(5'b01001, 2'd3, 2'd3);
        rd_sel = 2'd3; #1;
        n_vec++;
        if (rd_data !== 8'hFF || flag_c !== 1'b1) begin
            $display("FAIL dec_wrap: got R3=%h c=%b want FF 1", rd_data, flag_c); n_miss++;
        end
        run_cmd(5'b01000, 2'd3, 2'd3);
        rd_sel = 2'd3; #1;
        n_vec++;
        if (rd_data !== 8'h00 || {flag_c, flag_z, flag_s} !== 3'b110) begin
            $display("FAIL inc_wrap: got R3=%h czs=%b%b%b want 00 110", rd_data, flag_c, flag_z, flag_s);
            n_miss++;
        end
    endtask

    task automatic test_unsupported;
        run_cmd(5'b10000, 2'd0, 2'd1);
        run_cmd(5'b00010, 2'd1, 2'd2);
        run_cmd(5'b10110, 2'd2, 2'd2);
        run_cmd(5'b11111, 2'd3, 2'd0);
        for (int i = 0; i < NREGS; i++) begin
            rd_sel = AW'(i); #1;
            n_vec++;
            if (rd_data !== m_r[AW'(i)]) begin
                $display("FAIL unsup_reg R%0d: got %h want %h", i, rd_data, m_r[AW'(i)]); n_miss++;
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [4:0]    ops  [3] = '{5'b01000, 5'b00000, 5'b01001};
        logic [AW-1:0] dsts [3] = '{2'd1, 2'd2, 2'd1};
        logic [AW-1:0] srcs [3] = '{2'd0, 2'd1, 2'd3};
        int   want_at [3] = '{0, 3, 6};
        int   acc_at  [3] = '{-1, -1, -1};
        int   n_acc = 0;
        int   n_done = 0;
        int   start;
        exp_t e;
        @(negedge clk);
        start = cyc;
        cmd_valid = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (done) begin
                n_vec++;
                if (sb.size() == 0) begin
                    $display("FAIL b2b_spurious_done: got done with empty scoreboard"); n_miss++;
                end else begin
                    e = sb.pop_front();
                    n_done++;
                    if (cyc - e.acc != 2 || err !== e.err) begin
                        $display("FAIL b2b_retire: got latency %0d err %b want 2 %b", cyc - e.acc, err, e.err);
                        n_miss++;
                    end
                end
            end
            if (k < 9) begin
                n_vec++;
                if (cmd_ready !== (k % 3 == 0)) begin
                    $display("FAIL b2b_ready cycle %0d: got %b want %b", k, cmd_ready, (k % 3 == 0));
                    n_miss++;
                end
            end
            if (cmd_ready) begin
                if (n_acc < 3) begin
                    cmd_op = ops[n_acc]; cmd_dst = dsts[n_acc]; cmd_src = srcs[n_acc];
                    acc_at[n_acc] = cyc - start;
                    sb.push_back(model_apply(ops[n_acc], dsts[n_acc], srcs[n_acc], cyc));
                    n_acc++;
                end else begin
                    cmd_valid = 1'b0;
                end
            end else begin
                cmd_op = 5'($urandom); cmd_dst = AW'($urandom); cmd_src = AW'($urandom);
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (acc_at[i] != want_at[i]) begin
                $display("FAIL b2b_accept %0d: got cycle %0d want %0d", i, acc_at[i], want_at[i]); n_miss++;
            end
        end
        n_vec++;
        if (n_done != 3) begin
            $display("FAIL b2b_done_count: got %0d want 3", n_done); n_miss++;
        end
        sb.delete();
        for (int i = 0; i < NREGS; i++) begin
            rd_sel = AW'(i); #1;
            n_vec++;
            if (rd_data !== m_r[AW'(i)]) begin
                $display("FAIL b2b_reg R%0d: got %h want %h", i, rd_data, m_r[AW'(i)]); n_miss++;
            end
        end
    endtask

    task automatic test_reset_in_wb;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 5'b00000; cmd_dst = 2'd2; cmd_src = 2'd1;
        @(posedge clk);           // accept
        @(negedge clk);
        cmd_valid = 1'b0;
        @(posedge clk);           // enter WB
        #1 reset_n = 1'b0;
        for (int i = 0; i < NREGS; i++) m_r[i] = 8'h00;
        m_c = 1'b0; m_z = 1'b0; m_s = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({done, err, alu_a, alu_b, alu_op} !== 22'h0) begin
            $display("FAIL wb_reset_outputs: done=%b err=%b a=%h b=%h op=%h want all 0",
                     done, err, alu_a, alu_b, alu_op);
            n_miss++;
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (cmd_ready !== 1'b1 || done !== 1'b0) begin
            $display("FAIL wb_reset_release: got ready=%b done=%b want 1 0", cmd_ready, done); n_miss++;
        end
        n_vec++;
        if ({flag_c, flag_z, flag_s} !== 3'b000) begin
            $display("FAIL wb_reset_flags: got czs=%b%b%b want 000", flag_c, flag_z, flag_s); n_miss++;
        end
        for (int i = 0; i < NREGS; i++) begin
            rd_sel = AW'(i); #1;
            n_vec++;
            if (rd_data !== 8'h00) begin
                $display("FAIL wb_reset_reg R%0d: got %h want 00", i, rd_data); n_miss++;
            end
        end
        run_cmd(5'b01000, 2'd2, 2'd0);
        run_cmd(5'b01111, 2'd3, 2'd3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_setup();
        test_add();
        test_sub_self();
        test_inc_wrap();
        test_unsupported();
        test_back_to_back();
        test_reset_in_wb();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
